// File: rtl/mdio_frame_ctrl.sv
// Clause 22 MDIO frame controller: serialises one read or write frame per accepted
// command, generates MDC from mclk and returns read data with a one-cycle response pulse.
module mdio_frame_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] cfg_mdc_div,
    input  logic             cfg_no_pre,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rd,
    input  logic [4:0]       cmd_phy_addr,
    input  logic [4:0]       cmd_reg_addr,
    input  logic [15:0]      cmd_wdata,
    output logic             rsp_valid,
    output logic [15:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             busy,
    output logic             mdc,
    output logic             mdio_o,
    output logic             mdio_oe,
    input  logic             mdio_i
);

    typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA, DONE} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic [31:0]      sh_q, sh_d;
    logic [4:0]       bits_q, bits_d;
    logic             mdc_q, mdc_d;
    logic             mdo_q, mdo_d;
    logic             oe_q, oe_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             tick, rise, fall;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            sh_q    <= '0;
            bits_q  <= '0;
            mdc_q   <= 1'b0;
            mdo_q   <= 1'b0;
            oe_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            sh_q    <= sh_d;
            bits_q  <= bits_d;
            mdc_q   <= mdc_d;
            mdo_q   <= mdo_d;
            oe_q    <= oe_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        sh_d    = sh_q;
        bits_d  = bits_q;
        mdc_d   = mdc_q;
        mdo_d   = mdo_q;
        oe_d    = oe_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tick    = (cnt_q == div_q);
        rise    = tick && !mdc_q;
        fall    = tick && mdc_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                mdc_d = 1'b0;
                mdo_d = 1'b0;
                oe_d  = 1'b0;
                if (cmd_valid) begin
                    // ST, OP, PHYAD, REGAD, write TA and write data, sent MSB first
                    sh_d    = {2'b01, (cmd_rd ? 2'b10 : 2'b01), cmd_phy_addr,
                               cmd_reg_addr, 2'b10, cmd_wdata};
                    rd_d    = cmd_rd;
                    div_d   = cfg_mdc_div;
                    oe_d    = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (cfg_no_pre) begin
                        state_d = CMD;
                        bits_d  = 5'd13;
                        mdo_d   = 1'b0;
                    end else begin
                        state_d = PRE;
                        bits_d  = 5'd31;
                        mdo_d   = 1'b1;
                    end
                end
            end
            PRE, CMD, TA, DATA: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) mdc_d = ~mdc_q;
                if (rise && rd_q) begin
                    if (state_q == TA && bits_q == '0) err_d = mdio_i;
                    if (state_q == DATA) rdata_d = {rdata_q[14:0], mdio_i};
                end
                if (fall) begin
                    // sh_q[31] is the bit currently on the wire, sh_q[30] the next one
                    if (state_q != PRE) sh_d = {sh_q[30:0], 1'b0};
                    bits_d = bits_q - 1'b1;
                    mdo_d  = (state_q == PRE) ? 1'b1 : sh_q[30];
                    if (bits_q == '0) begin
                        if (state_q == PRE) begin
                            state_d = CMD;
                            bits_d  = 5'd13;
                            mdo_d   = sh_q[31];
                        end else if (state_q == CMD) begin
                            state_d = TA;
                            bits_d  = 5'd1;
                            if (rd_q) oe_d = 1'b0;
                        end else if (state_q == TA) begin
                            state_d = DATA;
                            bits_d  = 5'd15;
                        end else begin
                            state_d = DONE;
                            oe_d    = 1'b0;
                        end
                    end
                    if (!oe_d) mdo_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                mdc_d   = 1'b0;
                mdo_d   = 1'b0;
                oe_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdo_q;
    assign mdio_oe   = oe_q;

endmodule

// File: tb/tb_mdio_frame_ctrl.sv
// Directed bench for mdio_frame_ctrl: table of frames with hand-computed bitstreams,
// latencies and responses, plus held-valid and mid-frame reset sequences.
module tb_mdio_frame_ctrl;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic [7:0]  cfg_mdc_div;
    logic        cfg_no_pre;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    int total = 0;
    int bad   = 0;

    mdio_frame_ctrl #(.DIV_W(8)) dut (
        .mclk(mclk), .reset_n(reset_n), .cfg_mdc_div(cfg_mdc_div), .cfg_no_pre(cfg_no_pre),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic        rd;
        logic        no_pre;
        logic [7:0]  div;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wdata;
        logic        phy_float;
        logic        ta_bit;
        logic [15:0] phy_data;
        logic [63:0] exp_drv;
        int          exp_ndrv;
        int          exp_nbits;
        int          exp_lat;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // PHY model: value presented on mdio_i ahead of MDC rise number nr (0-based)
    function automatic logic phy_bit(input vec_t v, input int nr);
        int pre;
        pre = v.no_pre ? 0 : 32;
        if (v.phy_float) return 1'b1;
        if (nr == pre + 15) return v.ta_bit;
        if (nr >= pre + 16 && nr < pre + 32) return v.phy_data[15 - (nr - pre - 16)];
        return 1'b1;
    endfunction

    // Called and returns at a negedge; cycle 0 is the accept cycle.
    task automatic run_frame(input int idx, input bit hold, input bit chg, input bit keep);
        vec_t        v;
        int          cyc, nrise, ndrv, lat, accepts, viol;
        logic [63:0] cap;
        logic        pm, po, poe;
        v = vecs[idx];
        cfg_mdc_div  = v.div;
        cfg_no_pre   = v.no_pre;
        cmd_rd       = v.rd;
        cmd_phy_addr = v.phy;
        cmd_reg_addr = v.regad;
        cmd_wdata    = v.wdata;
        cmd_valid    = 1'b1;
        mdio_i       = phy_bit(v, 0);
        chk($sformatf("v%0d ready_at_accept", idx), cmd_ready, 1);
        accepts = (cmd_ready === 1'b1) ? 1 : 0;
        cyc = 0; nrise = 0; ndrv = 0; lat = -1; viol = 0; cap = '0;
        pm = mdc; po = mdio_o; poe = mdio_oe;
        while (lat < 0 && cyc < 2000) begin
            @(negedge mclk);
            cyc++;
            if (!hold) cmd_valid = 1'b0;
            if (chg && cyc == 10) begin
                cfg_mdc_div = v.div + 8'd2;
                cfg_no_pre  = ~v.no_pre;
            end
            if (cyc == 1) begin
                chk($sformatf("v%0d busy_c1", idx), busy, 1);
                chk($sformatf("v%0d ready_c1", idx), cmd_ready, 0);
                chk($sformatf("v%0d mdc_c1", idx), mdc, 0);
                chk($sformatf("v%0d oe_c1", idx), mdio_oe, 1);
                chk($sformatf("v%0d mdo_c1", idx), mdio_o, v.no_pre ? 0 : 1);
            end
            if (cmd_valid && cmd_ready) accepts++;
            if (busy && cmd_ready) viol++;
            if (cyc > 1 && mdio_oe && !poe) viol++;
            if (mdc && !pm) begin
                if (mdio_o !== po || mdio_oe !== poe) viol++;
                if (mdio_oe) begin
                    cap = {cap[62:0], mdio_o};
                    ndrv++;
                end
                nrise++;
                mdio_i = phy_bit(v, nrise);
            end
            if (rsp_valid) lat = cyc;
            pm = mdc; po = mdio_o; poe = mdio_oe;
        end
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d mdc_rises", idx), nrise, v.exp_nbits);
        chk($sformatf("v%0d driven_bits", idx), ndrv, v.exp_ndrv);
        chk($sformatf("v%0d stream", idx), cap, v.exp_drv);
        chk($sformatf("v%0d rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d err", idx), rsp_err, v.exp_err);
        chk($sformatf("v%0d accepts", idx), accepts, 1);
        chk($sformatf("v%0d edge_violations", idx), viol, 0);
        @(negedge mclk);
        if (!keep) cmd_valid = 1'b0;
        chk($sformatf("v%0d rsp_pulse_end", idx), rsp_valid, 0);
        chk($sformatf("v%0d ready_after", idx), cmd_ready, 1);
        chk($sformatf("v%0d idle_mdc_oe", idx), {mdc, mdio_oe, busy}, 0);
        chk($sformatf("v%0d rdata_hold", idx), {rsp_err, rsp_rdata}, {v.exp_err, v.exp_rdata});
    endtask

    initial begin
        int nr, cyc, pulses;
        logic pm;
        vecs[0] = '{1'b0, 1'b0, 8'd0, 5'h01, 5'h04, 16'hA5C3, 1'b0, 1'b0, 16'h0000,
                    64'hFFFF_FFFF_5092_A5C3, 64, 64, 129, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'd3, 5'h1F, 5'h00, 16'h0000, 1'b0, 1'b0, 16'h796D,
                    64'h1BE0, 14, 32, 257, 16'h796D, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'd1, 5'h05, 5'h1F, 16'h0000, 1'b1, 1'b1, 16'hFFFF,
                    64'h3FFF_FFFF_D8BF, 46, 64, 257, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 8'd2, 5'h12, 5'h0A, 16'h0001, 1'b0, 1'b0, 16'h0000,
                    64'h592A_0001, 32, 32, 193, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 8'd0, 5'h00, 5'h11, 16'hFFFF, 1'b0, 1'b0, 16'h8001,
                    64'h1811, 14, 32, 65, 16'h8001, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'd1, 5'h03, 5'h02, 16'h0000, 1'b0, 1'b1, 16'h1234,
                    64'h1862, 14, 32, 129, 16'h1234, 1'b1};

        reset_n = 1'b0; cfg_mdc_div = '0; cfg_no_pre = 1'b0; cmd_valid = 1'b0;
        cmd_rd = 1'b0; cmd_phy_addr = '0; cmd_reg_addr = '0; cmd_wdata = '0; mdio_i = 1'b1;
        #2;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        chk("rst rsp_err", rsp_err, 0);
        chk("rst pins", {mdc, mdio_o, mdio_oe}, 0);
        @(negedge mclk);
        @(negedge mclk);
        reset_n = 1'b1;
        @(negedge mclk);

        for (int i = 0; i < 6; i++) run_frame(i, 1'b0, 1'b0, 1'b0);

        // cmd_valid held across two frames, config disturbed mid-frame in the first
        run_frame(3, 1'b1, 1'b1, 1'b1);
        run_frame(4, 1'b1, 1'b0, 1'b0);

        // reset during bit 20 of a preamble write
        cfg_mdc_div = 8'd0; cfg_no_pre = 1'b0; cmd_rd = 1'b0;
        cmd_phy_addr = 5'h01; cmd_reg_addr = 5'h04; cmd_wdata = 16'hA5C3;
        cmd_valid = 1'b1;
        nr = 0; cyc = 0; pulses = 0; pm = mdc;
        while (nr < 21 && cyc < 500) begin
            @(negedge mclk);
            cyc++;
            cmd_valid = 1'b0;
            if (mdc && !pm) nr++;
            if (rsp_valid) pulses++;
            pm = mdc;
        end
        chk("pre_rst mdc_high", mdc, 1);
        chk("pre_rst busy", {busy, mdio_oe}, 2'b11);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst mdc", mdc, 0);
        chk("async_rst oe", mdio_oe, 0);
        chk("async_rst busy_ready", {busy, cmd_ready}, 2'b01);
        chk("async_rst mdo", mdio_o, 0);
        repeat (3) begin
            @(negedge mclk);
            if (rsp_valid) pulses++;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge mclk);
            if (rsp_valid) pulses++;
        end
        chk("rst no_rsp", pulses, 0);
        run_frame(0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
